ms6205_display_responder: RTL and testbench

- Display-side responder for the MS6205 character display write interface; receives address/data strobes from the host-side writer and handshakes with `ready`.
- Holds a character memory of 2^ADDR_W bytes with an auto-incrementing cursor.
- Supports a clear-screen command.
- Exposes a registered scan read port for the character generator / video path.

---
 rtl/ms6205_display_responder.sv | 150 +++++++++++++++
 tb/tb_ms6205_display_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ms6205_display_responder.sv
// MS6205 display-side write responder: character memory with an auto-incrementing
// cursor, a clear-screen command, a busy/ready handshake with a sticky overrun
// flag, and a registered scan read port for the video path.
//
// state   | meaning
// CLEAR   | filling memory with CLEAR_CHAR, one location per cycle; ready low
// IDLE    | ready high; a sampled strobe is accepted
// BUSY    | ready low for BUSY_CYCLES cycles after an accepted strobe
module ms6205_display_responder #(
  parameter int          ADDR_W      = 8,
  parameter int          BUSY_CYCLES = 4,
  parameter logic [7:0]  CLEAR_CHAR  = 8'h20,
  parameter logic [7:0]  CLR_CODE    = 8'h0C
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [7:0]        address,
  input  logic [7:0]        data,
  input  logic              write_addr,
  input  logic              write_data,
  output logic              ready,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [7:0]        scan_data,
  output logic [ADDR_W-1:0] cursor,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(BUSY_CYCLES + 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_BUSY
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [CNT_W-1:0]  busy_cnt;

  logic [7:0]        mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  logic              strobe;
  logic              is_clr_cmd;
  logic [ADDR_W-1:0] base_addr;

  assign strobe     = write_addr | write_data;
  assign is_clr_cmd = write_data && (data == CLR_CODE);
  // When both strobes arrive together the new address is applied before the data.
  assign base_addr  = write_addr ? address[ADDR_W-1:0] : cursor;

  // Single write port: clear fill while clearing, otherwise an accepted host data write.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr;
    mem_wdata = CLEAR_CHAR;
    if (state == S_CLEAR) begin
      mem_we = 1'b1;
    end else if (state == S_IDLE && write_data && !is_clr_cmd) begin
      mem_we    = 1'b1;
      mem_waddr = base_addr;
      mem_wdata = data;
    end
  end

  // Character memory write; contents are not reset, the clear sequence overwrites them.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered scan read, old data on a same-cycle write to the same address.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scan_data <= 8'h00;
    end else begin
      scan_data <= mem[scan_addr];
    end
  end

  // Control FSM: clear sequencing, strobe acceptance, busy timer, ready, cursor.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_CLEAR;
      clr_ptr  <= '0;
      busy_cnt <= '0;
      ready    <= 1'b0;
      cursor   <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == {ADDR_W{1'b1}}) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end else begin
            ready <= 1'b0;
          end
        end
        S_IDLE: begin
          if (is_clr_cmd) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
            cursor  <= '0;
            ready   <= 1'b0;
          end else if (strobe) begin
            state    <= S_BUSY;
            busy_cnt <= CNT_W'(BUSY_CYCLES);
            ready    <= (BUSY_CYCLES == 0);
            cursor   <= write_data ? base_addr + 1'b1 : base_addr;
          end else begin
            ready <= 1'b1;
          end
        end
        S_BUSY: begin
          busy_cnt <= busy_cnt - 1'b1;
          if (busy_cnt <= CNT_W'(1)) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end else begin
            ready <= 1'b0;
          end
        end
        default: begin
          state   <= S_CLEAR;
          clr_ptr <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a strobe while not ready sets it, and setting wins over clearing.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      overrun <= 1'b0;
    end else if (strobe && !ready) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ms6205_display_responder.sv
// Directed bench for ms6205_display_responder: table-driven host writes plus
// hand-written overrun, clear-screen and mid-busy reset sequences.
module tb_ms6205_display_responder;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] address;
  logic [7:0] data;
  logic       write_addr;
  logic       write_data;
  logic       ready;
  logic [7:0] scan_addr;
  logic [7:0] scan_data;
  logic [7:0] cursor;
  logic       overrun;
  logic       overrun_clr;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  ms6205_display_responder dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .address     (address),
    .data        (data),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .ready       (ready),
    .scan_addr   (scan_addr),
    .scan_data   (scan_data),
    .cursor      (cursor),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  typedef struct {
    logic       wa;
    logic       wd;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] cur;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] v;
  } rd_t;

  vec_t vecs [6];
  rd_t  rds  [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Counts falling edges until ready is seen high, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the sampling edge.
  task automatic do_strobe(input logic wa, input logic wd, input logic [7:0] a, input logic [7:0] d);
    address    = a;
    data       = d;
    write_addr = wa;
    write_data = wd;
    @(negedge Clk);
    write_addr = 1'b0;
    write_data = 1'b0;
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [7:0] v);
    scan_addr = a;
    @(negedge Clk);
    v = scan_data;
  endtask

  task automatic scan_all_clear(output int bad);
    logic [7:0] v;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      read_mem(8'(i), v);
      if (v !== 8'h20) bad++;
    end
  endtask

  initial begin
    int         n;
    int         bad;
    logic [7:0] v;

    vecs[0] = '{wa: 1'b1, wd: 1'b0, a: 8'h10, d: 8'h00, cur: 8'h10};
    vecs[1] = '{wa: 1'b0, wd: 1'b1, a: 8'h00, d: 8'h41, cur: 8'h11};
    vecs[2] = '{wa: 1'b0, wd: 1'b1, a: 8'h00, d: 8'h42, cur: 8'h12};
    vecs[3] = '{wa: 1'b1, wd: 1'b0, a: 8'hFF, d: 8'h00, cur: 8'hFF};
    vecs[4] = '{wa: 1'b0, wd: 1'b1, a: 8'h00, d: 8'h55, cur: 8'h00};
    vecs[5] = '{wa: 1'b1, wd: 1'b1, a: 8'h80, d: 8'h33, cur: 8'h81};

    rds[0] = '{a: 8'h10, v: 8'h41};
    rds[1] = '{a: 8'h11, v: 8'h42};
    rds[2] = '{a: 8'hFF, v: 8'h55};
    rds[3] = '{a: 8'h80, v: 8'h33};
    rds[4] = '{a: 8'h12, v: 8'h20};
    rds[5] = '{a: 8'h00, v: 8'h20};

    Rst_n       = 1'b0;
    address     = 8'h00;
    data        = 8'h00;
    write_addr  = 1'b0;
    write_data  = 1'b0;
    overrun_clr = 1'b0;
    scan_addr   = 8'h00;
    repeat (3) @(negedge Clk);

    chk("rst_ready",   32'(ready),     32'h0);
    chk("rst_cursor",  32'(cursor),    32'h0);
    chk("rst_overrun", 32'(overrun),   32'h0);
    chk("rst_scan",    32'(scan_data), 32'h0);

    Rst_n = 1'b1;
    wait_ready(n);
    chk("init_clear_cycles", 32'(n), 32'd256);
    scan_all_clear(bad);
    chk("init_clear_bad_locs", 32'(bad), 32'd0);
    chk("init_cursor",  32'(cursor),  32'h0);
    chk("init_overrun", 32'(overrun), 32'h0);

    for (int i = 0; i < 6; i++) begin
      wait_ready(n);
      do_strobe(vecs[i].wa, vecs[i].wd, vecs[i].a, vecs[i].d);
      wait_ready(n);
      chk($sformatf("vec%0d_busy", i),    32'(n),       32'd4);
      chk($sformatf("vec%0d_cursor", i),  32'(cursor),  32'(vecs[i].cur));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      read_mem(rds[i].a, v);
      chk($sformatf("rd%0d_mem", i), 32'(v), 32'(rds[i].v));
    end

    // Illegal strobe two cycles after an accepted write.
    wait_ready(n);
    do_strobe(1'b0, 1'b1, 8'h00, 8'h41);
    @(negedge Clk);
    do_strobe(1'b0, 1'b1, 8'h00, 8'h99);
    chk("ovr_set", 32'(overrun), 32'h1);
    wait_ready(n);
    chk("ovr_cursor", 32'(cursor), 32'h82);
    read_mem(8'h81, v);
    chk("ovr_mem81", 32'(v), 32'h41);
    read_mem(8'h82, v);
    chk("ovr_mem82_not_stored", 32'(v), 32'h20);

    // Set wins over clear in the same cycle.
    do_strobe(1'b1, 1'b0, 8'h82, 8'h00);
    overrun_clr = 1'b1;
    do_strobe(1'b1, 1'b0, 8'h05, 8'h00);
    overrun_clr = 1'b0;
    chk("ovr_set_priority", 32'(overrun), 32'h1);
    chk("ovr_ignored_addr", 32'(cursor),  32'h82);
    overrun_clr = 1'b1;
    @(negedge Clk);
    overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'h0);

    // Strobe held across acceptance: accepted once, then flagged.
    wait_ready(n);
    address    = 8'h00;
    data       = 8'h61;
    write_data = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    write_data = 1'b0;
    wait_ready(n);
    chk("held_cursor",  32'(cursor),  32'h83);
    chk("held_overrun", 32'(overrun), 32'h1);
    read_mem(8'h82, v);
    chk("held_mem82", 32'(v), 32'h61);
    read_mem(8'h83, v);
    chk("held_mem83", 32'(v), 32'h20);
    overrun_clr = 1'b1;
    @(negedge Clk);
    overrun_clr = 1'b0;

    // Clear-screen command.
    wait_ready(n);
    do_strobe(1'b0, 1'b1, 8'h00, 8'h0C);
    chk("cls_cursor", 32'(cursor), 32'h0);
    wait_ready(n);
    chk("cls_cycles", 32'(n), 32'd256);
    scan_all_clear(bad);
    chk("cls_bad_locs", 32'(bad), 32'd0);

    // Read-before-write, then reset in the middle of BUSY.
    scan_addr = 8'h00;
    @(negedge Clk);
    do_strobe(1'b0, 1'b1, 8'h00, 8'h77);
    chk("rbw_old_data", 32'(scan_data), 32'h20);
    do_strobe(1'b0, 1'b1, 8'h00, 8'h99);
    chk("rbw_new_data", 32'(scan_data), 32'h77);
    chk("busy_overrun", 32'(overrun),   32'h1);
    chk("busy_ready",   32'(ready),     32'h0);
    Rst_n = 1'b0;
    #1;
    chk("midrst_ready",   32'(ready),     32'h0);
    chk("midrst_cursor",  32'(cursor),    32'h0);
    chk("midrst_overrun", 32'(overrun),   32'h0);
    chk("midrst_scan",    32'(scan_data), 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    wait_ready(n);
    chk("midrst_clear_cycles", 32'(n), 32'd256);
    read_mem(8'h00, v);
    chk("midrst_mem00", 32'(v), 32'h20);
    chk("midrst_cursor_after", 32'(cursor), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
